// File: rtl/genram_loader.sv
// Run-time loadable synchronous RAM: a valid/ready word stream fills the table,
// and the registered read port matches the generic ROM's 1-cycle latency.
module genram_loader #(
    parameter int AW   = 4,
    parameter int DW   = 7,
    parameter int WRAP = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          finish,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic [AW:0]   count,
    output logic          busy,
    output logic          done
);

    // state | meaning
    // IDLE  | after reset, waiting for start; stream ignored
    // LOAD  | accepting words at the auto-incrementing write pointer
    // DONE  | load finished or ended early; table stable until next start

    localparam int            NPOS      = 2**AW;
    localparam logic [AW:0]   COUNT_MAX = (AW+1)'(NPOS);
    localparam logic [AW-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [AW-1:0] wr_ptr;
    logic          accept;
    logic          last_word;

    logic [DW-1:0] mem [NPOS];

    assign wr_ready  = (state == LOAD);
    assign busy      = wr_ready;
    assign done      = (state == DONE);
    assign accept    = wr_valid && wr_ready;
    assign last_word = accept && (wr_ptr == LAST_ADDR) && (WRAP == 0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state  <= LOAD;
                        wr_ptr <= '0;
                        count  <= '0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (count != COUNT_MAX)
                            count <= count + 1'b1;
                    end
                    // a word arriving with finish is still written and counted
                    if (finish || last_word)
                        state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Array kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr] <= wr_data;
    end

    // Read-before-write on an address collision falls out of the NBA ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_data <= '0;
        else
            rd_data <= mem[rd_addr];
    end

endmodule

// File: tb/tb_genram_loader.sv
// Bench for genram_loader: directed scenarios plus random traffic on a WRAP=0
// and a WRAP=1 instance, checked against an array-based model of the table.
module tb_genram_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start0, finish0, wr_valid0, wr_ready0, busy0, done0;
    logic [6:0] wr_data0, rd_data0;
    logic [3:0] rd_addr0;
    logic [4:0] count0;
    logic       start1, finish1, wr_valid1, wr_ready1, busy1, done1;
    logic [6:0] wr_data1, rd_data1;
    logic [3:0] rd_addr1;
    logic [4:0] count1;

    genram_loader #(.AW(4), .DW(7), .WRAP(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .finish(finish0),
        .wr_data(wr_data0), .wr_valid(wr_valid0), .wr_ready(wr_ready0),
        .rd_addr(rd_addr0), .rd_data(rd_data0), .count(count0),
        .busy(busy0), .done(done0)
    );

    genram_loader #(.AW(4), .DW(7), .WRAP(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .finish(finish1),
        .wr_data(wr_data1), .wr_valid(wr_valid1), .wr_ready(wr_ready1),
        .rd_addr(rd_addr1), .rd_data(rd_data1), .count(count1),
        .busy(busy1), .done(done1)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference: table contents, which entries hold a known value, loader
    // phase (0 idle, 1 loading, 2 done) and words written since start.
    logic [6:0] m_mem   [2][16];
    bit         m_known [2][16];
    int         m_ph    [2];
    int         m_wr    [2];
    logic [6:0] exp_rd  [2];
    bit         exp_ok  [2];

    function automatic logic [4:0] exp_cnt(input int k);
        return (m_wr[k] > 16) ? 5'd16 : 5'(m_wr[k]);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ph[k] = 0;
            m_wr[k] = 0;
        end
    endtask

    // Drive one cycle on instance k and advance the model by the same rules.
    task automatic cyc(input int k, input bit s, input bit f, input bit v,
                       input logic [6:0] d, input logic [3:0] ra);
        if (k == 0) begin
            start0 = s; finish0 = f; wr_valid0 = v; wr_data0 = d; rd_addr0 = ra;
        end else begin
            start1 = s; finish1 = f; wr_valid1 = v; wr_data1 = d; rd_addr1 = ra;
        end
        exp_rd[k] = m_mem[k][ra];
        exp_ok[k] = m_known[k][ra];
        case (m_ph[k])
            0, 2: if (s) begin
                m_ph[k] = 1;
                m_wr[k] = 0;
            end
            default: begin
                if (v) begin
                    m_mem[k][m_wr[k] % 16]   = d;
                    m_known[k][m_wr[k] % 16] = 1'b1;
                    m_wr[k]++;
                    if (k == 0 && m_wr[k] == 16) m_ph[k] = 2;
                end
                if (f) m_ph[k] = 2;
            end
        endcase
        @(posedge clk);
        #1;
        if (k == 0) begin
            start0 = 1'b0; finish0 = 1'b0; wr_valid0 = 1'b0;
        end else begin
            start1 = 1'b0; finish1 = 1'b0; wr_valid1 = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start0 = 0; finish0 = 0; wr_valid0 = 0; wr_data0 = '0; rd_addr0 = '0;
        start1 = 0; finish1 = 0; wr_valid1 = 0; wr_data1 = '0; rd_addr1 = '0;
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 16; a++) m_known[k][a] = 1'b0;
        model_reset();
        #12;
        n_total++;
        if ({busy0, done0, wr_ready0, count0, rd_data0} !== 15'd0)
            $display("FAIL reset_dut0: busy=%b done=%b ready=%b count=%0d rd=%h, want all 0",
                     busy0, done0, wr_ready0, count0, rd_data0);
        else n_pass++;
        n_total++;
        if ({busy1, done1, wr_ready1, count1, rd_data1} !== 15'd0)
            $display("FAIL reset_dut1: busy=%b done=%b ready=%b count=%0d rd=%h, want all 0",
                     busy1, done1, wr_ready1, count1, rd_data1);
        else n_pass++;
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(0, 0, 1, 1, 7'h11, 4'd0);
        n_total++;
        if (busy0 !== 1'b0 || count0 !== 5'd0)
            $display("FAIL idle_ignores: busy=%b count=%0d, want 0 0", busy0, count0);
        else n_pass++;
    endtask

    task automatic test_full_load();
        cyc(0, 1, 0, 0, 7'h00, 4'd0);
        n_total++;
        if (busy0 !== 1'b1 || wr_ready0 !== 1'b1 || count0 !== 5'd0)
            $display("FAIL full_start: busy=%b ready=%b count=%0d, want 1 1 0",
                     busy0, wr_ready0, count0);
        else n_pass++;
        for (int i = 0; i < 16; i++) begin
            cyc(0, 0, 0, 1, 7'(i), 4'($urandom_range(15)));
            n_total++;
            if (count0 !== exp_cnt(0) || busy0 !== (m_ph[0] == 1) || done0 !== (m_ph[0] == 2))
                $display("FAIL full_word%0d: count=%0d busy=%b done=%b, want %0d %b %b",
                         i, count0, busy0, done0, exp_cnt(0), m_ph[0] == 1, m_ph[0] == 2);
            else n_pass++;
        end
        n_total++;
        if (done0 !== 1'b1 || count0 !== 5'd16 || wr_ready0 !== 1'b0)
            $display("FAIL full_end: done=%b count=%0d ready=%b, want 1 16 0",
                     done0, count0, wr_ready0);
        else n_pass++;
        for (int i = 0; i < 16; i++) begin
            cyc(0, 0, 0, 0, 7'h00, 4'(i));
            n_total++;
            if (rd_data0 !== 7'(i))
                $display("FAIL full_read%0d: got %h want %h", i, rd_data0, 7'(i));
            else n_pass++;
        end
    endtask

    task automatic test_valid_toggle();
        logic [6:0] want [3];
        want = '{7'h3F, 7'h06, 7'h5B};
        cyc(0, 1, 0, 0, 7'h00, 4'd0);
        cyc(0, 0, 0, 1, 7'h3F, 4'd0);
        cyc(0, 0, 0, 0, 7'($urandom), 4'd0);
        cyc(0, 0, 0, 1, 7'h06, 4'd0);
        cyc(0, 0, 0, 0, 7'($urandom), 4'd0);
        cyc(0, 0, 0, 1, 7'h5B, 4'd0);
        n_total++;
        if (count0 !== 5'd3 || busy0 !== 1'b1)
            $display("FAIL toggle_count: count=%0d busy=%b, want 3 1", count0, busy0);
        else n_pass++;
        cyc(0, 0, 1, 0, 7'h00, 4'd0);
        n_total++;
        if (done0 !== 1'b1) $display("FAIL toggle_finish: done=%b want 1", done0);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 7'h00, 4'(i));
            n_total++;
            if (rd_data0 !== ((i < 3) ? want[i] : 7'h03))
                $display("FAIL toggle_read%0d: got %h want %h", i, rd_data0,
                         (i < 3) ? want[i] : 7'h03);
            else n_pass++;
        end
    endtask

    task automatic test_finish_with_word();
        logic [6:0] w6;
        cyc(0, 1, 0, 0, 7'h00, 4'd0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 7'($urandom), 4'd0);
        w6 = 7'($urandom);
        cyc(0, 0, 1, 1, w6, 4'd0);
        n_total++;
        if (done0 !== 1'b1 || count0 !== 5'd6)
            $display("FAIL finish_word: done=%b count=%0d, want 1 6", done0, count0);
        else n_pass++;
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 7'h7F, 4'd0);
        n_total++;
        if (count0 !== 5'd6 || done0 !== 1'b1)
            $display("FAIL done_ignores: count=%0d done=%b, want 6 1", count0, done0);
        else n_pass++;
        cyc(0, 0, 0, 0, 7'h00, 4'd5);
        n_total++;
        if (rd_data0 !== w6) $display("FAIL finish_addr5: got %h want %h", rd_data0, w6);
        else n_pass++;
        cyc(0, 0, 0, 0, 7'h00, 4'd6);
        n_total++;
        if (rd_data0 !== 7'h06) $display("FAIL finish_addr6: got %h want 06", rd_data0);
        else n_pass++;
    endtask

    task automatic test_read_before_write();
        cyc(0, 1, 0, 0, 7'h00, 4'd0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 7'($urandom_range(125)), 4'd0);
        cyc(0, 0, 0, 1, 7'h7E, 4'd3);
        n_total++;
        if (!exp_ok[0] || rd_data0 !== exp_rd[0] || rd_data0 === 7'h7E)
            $display("FAIL rbw_old: got %h want %h", rd_data0, exp_rd[0]);
        else n_pass++;
        cyc(0, 0, 0, 0, 7'h00, 4'd3);
        n_total++;
        if (rd_data0 !== 7'h7E) $display("FAIL rbw_new: got %h want 7e", rd_data0);
        else n_pass++;
        cyc(0, 0, 1, 0, 7'h00, 4'd0);
    endtask

    task automatic test_wrap();
        cyc(1, 1, 0, 0, 7'h00, 4'd0);
        for (int i = 0; i < 18; i++) begin
            cyc(1, 0, 0, 1, 7'(8'h40 + i), 4'd0);
            n_total++;
            if (count1 !== exp_cnt(1) || busy1 !== 1'b1)
                $display("FAIL wrap_word%0d: count=%0d busy=%b, want %0d 1",
                         i, count1, busy1, exp_cnt(1));
            else n_pass++;
        end
        n_total++;
        if (count1 !== 5'd16) $display("FAIL wrap_sat: count=%0d want 16", count1);
        else n_pass++;
        cyc(1, 0, 0, 0, 7'h00, 4'd0);
        n_total++;
        if (rd_data1 !== 7'h50 || busy1 !== 1'b1)
            $display("FAIL wrap_addr0: got %h busy=%b, want 50 1", rd_data1, busy1);
        else n_pass++;
        cyc(1, 0, 0, 0, 7'h00, 4'd1);
        n_total++;
        if (rd_data1 !== 7'h51) $display("FAIL wrap_addr1: got %h want 51", rd_data1);
        else n_pass++;
        cyc(1, 0, 0, 0, 7'h00, 4'd2);
        n_total++;
        if (rd_data1 !== 7'h42) $display("FAIL wrap_addr2: got %h want 42", rd_data1);
        else n_pass++;
        cyc(1, 0, 1, 0, 7'h00, 4'd0);
        n_total++;
        if (done1 !== 1'b1 || busy1 !== 1'b0)
            $display("FAIL wrap_finish: done=%b busy=%b, want 1 0", done1, busy1);
        else n_pass++;
    endtask

    task automatic test_reset_midload();
        logic [6:0] w0;
        cyc(0, 1, 0, 0, 7'h00, 4'd0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 7'($urandom), 4'd0);
        wr_valid0 = 1'b1;
        wr_data0  = ~m_mem[0][4];
        #2 rst = 1'b1;
        #1;
        model_reset();
        n_total++;
        if ({busy0, done0, wr_ready0, count0, rd_data0} !== 15'd0)
            $display("FAIL reset_mid: busy=%b done=%b ready=%b count=%0d rd=%h, want all 0",
                     busy0, done0, wr_ready0, count0, rd_data0);
        else n_pass++;
        wr_valid0 = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(0, 1, 0, 0, 7'h00, 4'd0);
        n_total++;
        if (count0 !== 5'd0 || busy0 !== 1'b1)
            $display("FAIL restart: count=%0d busy=%b, want 0 1", count0, busy0);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, 7'h00, 4'(i));
            n_total++;
            if (!exp_ok[0] || rd_data0 !== exp_rd[0])
                $display("FAIL retain%0d: got %h want %h", i, rd_data0, exp_rd[0]);
            else n_pass++;
        end
        w0 = 7'($urandom);
        cyc(0, 0, 0, 1, w0, 4'd0);
        cyc(0, 0, 0, 0, 7'h00, 4'd0);
        n_total++;
        if (rd_data0 !== w0 || count0 !== 5'd1)
            $display("FAIL restart_addr0: got %h count=%0d, want %h 1", rd_data0, count0, w0);
        else n_pass++;
    endtask

    task automatic test_random();
        logic       ob_busy, ob_done, ob_ready;
        logic [4:0] ob_cnt;
        logic [6:0] ob_rd;
        for (int n = 0; n < 400; n++) begin
            int k;
            k = int'($urandom_range(1));
            cyc(k, ($urandom_range(9) == 0), ($urandom_range(11) == 0),
                ($urandom_range(2) != 0), 7'($urandom), 4'($urandom));
            ob_busy  = (k == 0) ? busy0 : busy1;
            ob_done  = (k == 0) ? done0 : done1;
            ob_ready = (k == 0) ? wr_ready0 : wr_ready1;
            ob_cnt   = (k == 0) ? count0 : count1;
            ob_rd    = (k == 0) ? rd_data0 : rd_data1;
            n_total++;
            if (ob_busy !== (m_ph[k] == 1) || ob_ready !== (m_ph[k] == 1) ||
                ob_done !== (m_ph[k] == 2) || ob_cnt !== exp_cnt(k))
                $display("FAIL rand%0d_dut%0d: busy=%b ready=%b done=%b count=%0d, want %b %b %b %0d",
                         n, k, ob_busy, ob_ready, ob_done, ob_cnt,
                         m_ph[k] == 1, m_ph[k] == 1, m_ph[k] == 2, exp_cnt(k));
            else n_pass++;
            if (exp_ok[k]) begin
                n_total++;
                if (ob_rd !== exp_rd[k])
                    $display("FAIL rand%0d_rd_dut%0d: got %h want %h", n, k, ob_rd, exp_rd[k]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_valid_toggle();
        test_finish_with_word();
        test_read_before_write();
        test_wrap();
        test_reset_midload();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
